regfile_writeback_arbiter: RTL and testbench
============================================

Name: regfile_writeback_arbiter

Overview:
- Producer side of the register file write port.
- Accepts completed results from two sources, the single-cycle ALU and the multi-cycle load unit, over valid/ready handshakes.
- Arbitrates them onto the single register-file write port through a registered write stage.
- Keeps a pending-destination scoreboard so issue logic can detect RAW and WAW hazards against in-flight writes.

Parameters:
- DATA_WIDTH, 32, width of result data and write port data.
- STARVE_LIMIT, 4, consecutive lost-arbitration cycles after which the load source wins; range 1..15.

Ports:
- i_Clock  in  1  clock, rising edge
- i_Reset_n  in  1  asynchronous active-low reset
- i_IssueValid  in  1  issue stage presents an instruction
- i_IssueRd  in  5  destination register of issuing instruction
- o_IssueReady  out  1  issue may proceed (no WAW conflict)
- i_IssueRs1  in  5  source register 1 of issuing instruction
- i_IssueRs2  in  5  source register 2 of issuing instruction
- o_Rs1Busy  out  1  rs1 has a pending, uncommitted write
- o_Rs2Busy  out  1  rs2 has a pending, uncommitted write
- i_AluValid  in  1  ALU result valid
- i_AluRd  in  5  ALU result destination
- i_AluData  in  DATA_WIDTH  ALU result
- o_AluReady  out  1  ALU result accepted this cycle
- i_LoadValid  in  1  load result valid
- i_LoadRd  in  5  load result destination
- i_LoadData  in  DATA_WIDTH  load result
- o_LoadReady  out  1  load result accepted this cycle
- o_WriteEnable  out  1  register file write enable
- o_RegDest  out  5  register file write address
- o_DataIn  out  DATA_WIDTH  register file write data
- o_ScoreboardError  out  1  sticky protocol error flag

Behaviour:
- Reset (async assert, sync release):
  - Scoreboard pending[31:1] = 0, starve counter = 0.
  - o_WriteEnable = 0, o_RegDest = 0, o_DataIn = 0, o_ScoreboardError = 0.
  - All combinational outputs follow from these reset values.
- Scoreboard:
  - Bit r is set at a clock edge when i_IssueValid && o_IssueReady && i_IssueRd == r && r != 0.
  - Bit r is cleared at the edge ending a cycle in which o_WriteEnable && o_RegDest == r.
  - Register x0 is never pending and never busy.
- o_IssueReady = !pending[i_IssueRd] (always 1 for rd = 0).
  - Uses the current-cycle scoreboard, so an issue stalls even when the same register commits this cycle.
  - Set and clear of the same bit in one cycle therefore cannot occur.
- o_RsNBusy = pending[i_IssueRsN] (without bypass, see Optional Feature).
- Arbitration (combinational ready, one winner per cycle):
  - Only the ALU valid: ALU wins.
  - Only the load valid: load wins.
  - Both valid: ALU wins unless starve counter >= STARVE_LIMIT, then load wins.
  - o_AluReady / o_LoadReady asserted only for the winner.
- Starve counter:
  - Increments (saturating at 15) each cycle the load is valid and loses.
  - Clears when the load wins or i_LoadValid is low.
- Latency:
  - Result accepted at edge N produces o_WriteEnable = 1 with that rd/data during cycle N+1.
  - The register file captures it at edge N+1.
  - With no winner at edge N, o_WriteEnable = 0 in cycle N+1; o_RegDest/o_DataIn hold their previous values.
- Back-to-back: one write per cycle sustained; no bubble between consecutive winners.
- Result with rd = 0: handshake completes, o_WriteEnable stays 0, no scoreboard change.
- Result with rd != 0 whose pending bit is 0 at acceptance: write still performed; o_ScoreboardError set and held until reset.
- Source handshake rule: a source holding valid must keep rd/data stable until its ready; the block does not check this.
- Reset mid-operation: any in-flight write is dropped, the scoreboard clears, and nothing is written after reset release until a new result is accepted.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: adds outputs o_Rs1BypassValid, o_Rs2BypassValid (1 bit each) and o_Rs1BypassData, o_Rs2BypassData (DATA_WIDTH each).
  - o_RsNBypassValid = o_WriteEnable && o_RegDest == i_IssueRsN && i_IssueRsN != 0.
  - o_RsNBypassData = o_DataIn.
  - o_RsNBusy = pending[rsN] && !o_RsNBypassValid.
- Undefined: the bypass ports do not exist; o_RsNBusy stays asserted through the commit cycle.

Test Plan:
- Reset then idle -> o_WriteEnable = 0, all busy = 0, o_IssueReady = 1, o_ScoreboardError = 0.
- Issue rd = 5; next cycle ALU result rd = 5, data 0xDEADBEEF -> o_AluReady = 1; next cycle o_WriteEnable = 1, o_RegDest = 5, o_DataIn = 0xDEADBEEF; o_Rs1Busy (rs1 = 5) high until after that commit edge; issue of rd = 5 stalls (o_IssueReady = 0) throughout.
- ALU and load both valid continuously, STARVE_LIMIT = 4 -> ALU wins 4 cycles, load wins the 5th, counter clears, pattern repeats.
- ALU result rd = 0, data 0x1234 -> o_AluReady = 1, no write cycle, scoreboard unchanged.
- Load result rd = 9 with pending[9] = 0 -> write to x9 performed, o_ScoreboardError = 1 and stays 1 until i_Reset_n low.
- With REGFILE_WB_BYPASS_EN, issue rs1 = 7 during the commit cycle of rd = 7, data 0x55 -> o_Rs1Busy = 0, o_Rs1BypassValid = 1, o_Rs1BypassData = 0x55.
- Assert i_Reset_n low mid-write -> o_WriteEnable drops immediately, scoreboard clears.

Source files
------------

// File: rtl/regfile_writeback_arbiter_if.sv
// Bundle of issue, ALU/load result handshakes and register-file write port signals.
// REGFILE_WB_BYPASS_EN adds the rs1/rs2 bypass outputs.
interface regfile_writeback_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_IssueValid;
    logic [4:0]            i_IssueRd;
    logic                  o_IssueReady;
    logic [4:0]            i_IssueRs1;
    logic [4:0]            i_IssueRs2;
    logic                  o_Rs1Busy;
    logic                  o_Rs2Busy;
    logic                  i_AluValid;
    logic [4:0]            i_AluRd;
    logic [DATA_WIDTH-1:0] i_AluData;
    logic                  o_AluReady;
    logic                  i_LoadValid;
    logic [4:0]            i_LoadRd;
    logic [DATA_WIDTH-1:0] i_LoadData;
    logic                  o_LoadReady;
    logic                  o_WriteEnable;
    logic [4:0]            o_RegDest;
    logic [DATA_WIDTH-1:0] o_DataIn;
    logic                  o_ScoreboardError;
`ifdef REGFILE_WB_BYPASS_EN
    logic                  o_Rs1BypassValid;
    logic                  o_Rs2BypassValid;
    logic [DATA_WIDTH-1:0] o_Rs1BypassData;
    logic [DATA_WIDTH-1:0] o_Rs2BypassData;
`endif

    modport master (
        output i_IssueValid, i_IssueRd, i_IssueRs1, i_IssueRs2,
        output i_AluValid, i_AluRd, i_AluData,
        output i_LoadValid, i_LoadRd, i_LoadData,
        input  o_IssueReady, o_Rs1Busy, o_Rs2Busy, o_AluReady, o_LoadReady,
        input  o_WriteEnable, o_RegDest, o_DataIn, o_ScoreboardError
`ifdef REGFILE_WB_BYPASS_EN
        , input o_Rs1BypassValid, o_Rs2BypassValid, o_Rs1BypassData, o_Rs2BypassData
`endif
    );

    modport slave (
        input  i_IssueValid, i_IssueRd, i_IssueRs1, i_IssueRs2,
        input  i_AluValid, i_AluRd, i_AluData,
        input  i_LoadValid, i_LoadRd, i_LoadData,
        output o_IssueReady, o_Rs1Busy, o_Rs2Busy, o_AluReady, o_LoadReady,
        output o_WriteEnable, o_RegDest, o_DataIn, o_ScoreboardError
`ifdef REGFILE_WB_BYPASS_EN
        , output o_Rs1BypassValid, o_Rs2BypassValid, o_Rs1BypassData, o_Rs2BypassData
`endif
    );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// ALU/load writeback arbiter with registered write stage and pending-destination scoreboard.
// Optional rs1/rs2 commit-cycle bypass enabled by REGFILE_WB_BYPASS_EN.
module regfile_writeback_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic                   i_Clock,
    input logic                   i_Reset_n,
    regfile_writeback_arbiter_if.slave bus
);
    typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_LOAD} src_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    src_e                  winner;
    logic [31:0]           pending;
    logic [31:0]           pendingNext;
    logic [3:0]            starveCnt;
    logic                  wrEn;
    logic [4:0]            wrDest;
    logic [DATA_WIDTH-1:0] wrData;
    logic                  sbError;
    logic [4:0]            accRd;
    logic [DATA_WIDTH-1:0] accData;
    logic                  accWrite;
    logic                  issueFire;

    always_comb begin
        winner = SRC_NONE;
        if (bus.i_AluValid && (!bus.i_LoadValid || starveCnt < STARVE_LIM))
            winner = SRC_ALU;
        else if (bus.i_LoadValid)
            winner = SRC_LOAD;
    end

    always_comb begin
        accRd   = 5'd0;
        accData = '0;
        case (winner)
            SRC_ALU: begin
                accRd   = bus.i_AluRd;
                accData = bus.i_AluData;
            end
            SRC_LOAD: begin
                accRd   = bus.i_LoadRd;
                accData = bus.i_LoadData;
            end
            default: ;
        endcase
    end

    // rd = 0 results still handshake but never reach the write port
    assign accWrite  = (winner != SRC_NONE) && (accRd != 5'd0);
    assign issueFire = bus.i_IssueValid && bus.o_IssueReady;

    always_comb begin
        pendingNext = pending;
        if (wrEn)
            pendingNext[wrDest] = 1'b0;
        if (issueFire && bus.i_IssueRd != 5'd0)
            pendingNext[bus.i_IssueRd] = 1'b1;
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            pending   <= '0;
            starveCnt <= '0;
            wrEn      <= 1'b0;
            wrDest    <= '0;
            wrData    <= '0;
            sbError   <= 1'b0;
        end else begin
            pending <= pendingNext;
            if (bus.i_LoadValid && winner != SRC_LOAD)
                starveCnt <= (starveCnt == 4'd15) ? starveCnt : starveCnt + 4'd1;
            else
                starveCnt <= '0;
            wrEn <= accWrite;
            if (accWrite) begin
                wrDest <= accRd;
                wrData <= accData;
                if (!pending[accRd])
                    sbError <= 1'b1;
            end
        end
    end

    assign bus.o_AluReady        = (winner == SRC_ALU);
    assign bus.o_LoadReady       = (winner == SRC_LOAD);
    assign bus.o_IssueReady      = !pending[bus.i_IssueRd];
    assign bus.o_WriteEnable     = wrEn;
    assign bus.o_RegDest         = wrDest;
    assign bus.o_DataIn          = wrData;
    assign bus.o_ScoreboardError = sbError;

`ifdef REGFILE_WB_BYPASS_EN
    assign bus.o_Rs1BypassValid = wrEn && (wrDest == bus.i_IssueRs1) && (bus.i_IssueRs1 != 5'd0);
    assign bus.o_Rs2BypassValid = wrEn && (wrDest == bus.i_IssueRs2) && (bus.i_IssueRs2 != 5'd0);
    assign bus.o_Rs1BypassData  = wrData;
    assign bus.o_Rs2BypassData  = wrData;
    assign bus.o_Rs1Busy        = pending[bus.i_IssueRs1] && !bus.o_Rs1BypassValid;
    assign bus.o_Rs2Busy        = pending[bus.i_IssueRs2] && !bus.o_Rs2BypassValid;
`else
    assign bus.o_Rs1Busy        = pending[bus.i_IssueRs1];
    assign bus.o_Rs2Busy        = pending[bus.i_IssueRs2];
`endif
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Bench for regfile_writeback_arbiter: vector table plus starvation, bypass and reset sequences.
// Bypass checks are compiled in when REGFILE_WB_BYPASS_EN is defined.
module tb_regfile_writeback_arbiter;
    typedef struct {
        logic        issueValid;
        logic [4:0]  issueRd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        aluValid;
        logic [4:0]  aluRd;
        logic [31:0] aluData;
        logic        loadValid;
        logic [4:0]  loadRd;
        logic [31:0] loadData;
        logic        expIssueReady;
        logic        expRs1Busy;
        logic        expRs2Busy;
        logic        expAluReady;
        logic        expLoadReady;
        logic        expErr;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        i_Clock = 1'b0;
    logic        i_Reset_n;
    int unsigned checks = 0;
    int unsigned errors = 0;
    wr_t         expQ[$];
    vec_t        vecs[9];

    always #5 i_Clock = ~i_Clock;

    regfile_writeback_arbiter_if #(.DATA_WIDTH(32)) bus ();

    regfile_writeback_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .i_Clock  (i_Clock),
        .i_Reset_n(i_Reset_n),
        .bus      (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [4:0] ird, input logic [4:0] r1,
                                input logic [4:0] r2, input logic av, input logic [4:0] ard,
                                input logic [31:0] ad, input logic lv, input logic [4:0] lrd,
                                input logic [31:0] ld, input logic eIr, input logic eB1,
                                input logic eB2, input logic eAr, input logic eLr, input logic eErr);
        vec_t v;
        v.issueValid = iv;  v.issueRd = ird; v.rs1 = r1; v.rs2 = r2;
        v.aluValid = av;    v.aluRd = ard;   v.aluData = ad;
        v.loadValid = lv;   v.loadRd = lrd;  v.loadData = ld;
        v.expIssueReady = eIr; v.expRs1Busy = eB1; v.expRs2Busy = eB2;
        v.expAluReady = eAr;   v.expLoadReady = eLr; v.expErr = eErr;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.i_IssueValid = v.issueValid;
        bus.i_IssueRd    = v.issueRd;
        bus.i_IssueRs1   = v.rs1;
        bus.i_IssueRs2   = v.rs2;
        bus.i_AluValid   = v.aluValid;
        bus.i_AluRd      = v.aluRd;
        bus.i_AluData    = v.aluData;
        bus.i_LoadValid  = v.loadValid;
        bus.i_LoadRd     = v.loadRd;
        bus.i_LoadData   = v.loadData;
    endtask

    task automatic checkWrite(input string tag);
        wr_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk({tag, ".we"},   32'(bus.o_WriteEnable), 32'd1);
            chk({tag, ".dest"}, 32'(bus.o_RegDest),     32'(e.rd));
            chk({tag, ".data"}, bus.o_DataIn,           e.data);
        end else begin
            chk({tag, ".we"}, 32'(bus.o_WriteEnable), 32'd0);
        end
    endtask

    // Called at posedge+1; checks combinational outputs mid-cycle, the write stage after the edge.
    task automatic applyVec(input vec_t v, input string tag);
        drive(v);
        #4;
        chk({tag, ".issueReady"}, 32'(bus.o_IssueReady), 32'(v.expIssueReady));
        chk({tag, ".rs1Busy"},    32'(bus.o_Rs1Busy),    32'(v.expRs1Busy));
        chk({tag, ".rs2Busy"},    32'(bus.o_Rs2Busy),    32'(v.expRs2Busy));
        chk({tag, ".aluReady"},   32'(bus.o_AluReady),   32'(v.expAluReady));
        chk({tag, ".loadReady"},  32'(bus.o_LoadReady),  32'(v.expLoadReady));
        if (v.expAluReady && v.aluRd != 5'd0)
            expQ.push_back('{v.aluRd, v.aluData});
        if (v.expLoadReady && v.loadRd != 5'd0)
            expQ.push_back('{v.loadRd, v.loadData});
        @(posedge i_Clock);
        #1;
        checkWrite(tag);
        chk({tag, ".err"}, 32'(bus.o_ScoreboardError), 32'(v.expErr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   loadsWon;
        logic lw;
        logic rowBusy;

`ifdef REGFILE_WB_BYPASS_EN
        rowBusy = 1'b0;
`else
        rowBusy = 1'b1;
`endif
        //           iv rd  rs1 rs2 av ard adata          lv lrd ldata        eIr eB1     eB2 eAr eLr eErr
        vecs[0] = mk(0, 5,  5,  0,  0, 0, 32'h0,          0, 0,  32'h0,       1,  0,      0,  0,  0,  0);
        vecs[1] = mk(1, 5,  5,  0,  0, 0, 32'h0,          0, 0,  32'h0,       1,  0,      0,  0,  0,  0);
        vecs[2] = mk(1, 5,  5,  0,  1, 5, 32'hDEADBEEF,   0, 0,  32'h0,       0,  1,      0,  1,  0,  0);
        vecs[3] = mk(1, 5,  5,  0,  0, 0, 32'h0,          0, 0,  32'h0,       0,  rowBusy,0,  0,  0,  0);
        vecs[4] = mk(0, 5,  5,  0,  0, 0, 32'h0,          0, 0,  32'h0,       1,  0,      0,  0,  0,  0);
        vecs[5] = mk(0, 0,  0,  0,  1, 0, 32'h1234,       0, 0,  32'h0,       1,  0,      0,  1,  0,  0);
        vecs[6] = mk(0, 0,  0,  0,  0, 0, 32'h0,          0, 0,  32'h0,       1,  0,      0,  0,  0,  0);
        vecs[7] = mk(0, 0,  0,  0,  0, 0, 32'h0,          1, 9,  32'hCAFE0009,1,  0,      0,  0,  1,  1);
        vecs[8] = mk(0, 0,  0,  9,  0, 0, 32'h0,          0, 0,  32'h0,       1,  0,      0,  0,  0,  1);

        i_Reset_n = 1'b0;
        drive(mk(0, 5, 5, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge i_Clock);
        #1;
        chk("reset.we",         32'(bus.o_WriteEnable),     32'd0);
        chk("reset.dest",       32'(bus.o_RegDest),         32'd0);
        chk("reset.data",       bus.o_DataIn,               32'd0);
        chk("reset.err",        32'(bus.o_ScoreboardError), 32'd0);
        chk("reset.issueReady", 32'(bus.o_IssueReady),      32'd1);
        chk("reset.rs1Busy",    32'(bus.o_Rs1Busy),         32'd0);
        chk("reset.rs2Busy",    32'(bus.o_Rs2Busy),         32'd0);
        @(negedge i_Clock);
        i_Reset_n = 1'b1;
        @(posedge i_Clock);
        #1;
        chk("release.we", 32'(bus.o_WriteEnable), 32'd0);

        for (int i = 0; i < 9; i++)
            applyVec(vecs[i], $sformatf("row%0d", i));

        // Both sources valid throughout: ALU wins four, load wins the fifth, repeating.
        loadsWon = 0;
        for (int i = 0; i < 10; i++) begin
            lw = (i % 5 == 4);
            applyVec(mk(0, 0, 0, 0, 1, 5'(20 + i % 8), 32'(i + 100), 1, 5'(10 + loadsWon),
                        32'(32'h1000 + loadsWon), 1, 0, 0, !lw, lw, 1),
                     $sformatf("starve%0d", i));
            if (lw)
                loadsWon++;
        end

`ifdef REGFILE_WB_BYPASS_EN
        applyVec(mk(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1), "byp.issue");
        applyVec(mk(0, 7, 7, 0, 1, 7, 32'h55, 0, 0, 0, 0, 1, 0, 1, 0, 1), "byp.alu");
        bus.i_IssueRs1 = 5'd7;
        #1;
        chk("byp.valid", 32'(bus.o_Rs1BypassValid), 32'd1);
        chk("byp.data",  bus.o_Rs1BypassData,       32'h55);
        chk("byp.busy",  32'(bus.o_Rs1Busy),        32'd0);
        applyVec(mk(0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "byp.commit");
`endif

        applyVec(mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1), "rst.issue");
        applyVec(mk(0, 3, 3, 0, 1, 3, 32'h33, 0, 0, 0, 0, 1, 0, 1, 0, 1), "rst.alu");
        drive(mk(0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        i_Reset_n = 1'b0;
        #1;
        chk("rstmid.we",         32'(bus.o_WriteEnable),     32'd0);
        chk("rstmid.dest",       32'(bus.o_RegDest),         32'd0);
        chk("rstmid.data",       bus.o_DataIn,               32'd0);
        chk("rstmid.err",        32'(bus.o_ScoreboardError), 32'd0);
        chk("rstmid.rs1Busy",    32'(bus.o_Rs1Busy),         32'd0);
        chk("rstmid.issueReady", 32'(bus.o_IssueReady),      32'd1);
        expQ.delete();
        @(negedge i_Clock);
        i_Reset_n = 1'b1;
        @(posedge i_Clock);
        #1;
        chk("rstmid.release.we", 32'(bus.o_WriteEnable), 32'd0);
        applyVec(mk(0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "rst.after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
